// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the step sequencer: direction codes, FSM state encoding
// and the path-width / coordinate field width.
package step_sequencer_pkg;

    localparam int WIDTH_W = 5;

    localparam logic [1:0] DIR_DOWN  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_DIR = 3'd1,
        S_SCAN     = 3'd2,
        S_SETTLE   = 3'd3,
        S_PRESENT  = 3'd4
    } state_t;

endpackage

// File: rtl/step_timeout_cnt.sv
// Idle-cycle watchdog for the SCAN phase: counts cycles without a pixel and
// flags expiry on the cycle that would reach TIMEOUT_CYC.
module step_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Expiry is combinational so the owner can act on the TIMEOUT_CYC-th idle edge.
    assign expired = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: takes a direction proposal, scans 2*width+1 pixels, waits out
// the evaluator latency and presents the resulting step with a valid/ready handshake.
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023,
    parameter int MIN_WIDTH   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dir_valid,
    input  logic [1:0]         dir_in,
    input  logic [WIDTH_W-1:0] width_in,
    input  logic               video_data_valid,
    input  logic [WIDTH_W-1:0] coord_in,
    output logic               isDirDefined,
    output logic [1:0]         direction,
    output logic               longStep,
    output logic [WIDTH_W-1:0] pathWidth,
    output logic               step_valid,
    output logic [1:0]         step_dir,
    output logic [WIDTH_W-1:0] step_coord,
    input  logic               step_ready,
    output logic               busy,
    output logic               lost
);

    localparam logic [WIDTH_W-1:0] MIN_W = WIDTH_W'(MIN_WIDTH);

    function automatic logic [WIDTH_W-1:0] clamp_width(input logic [WIDTH_W-1:0] w);
        if (w < MIN_W) return MIN_W;
        return w;
    endfunction

    state_t             state;
    logic [WIDTH_W-1:0] pix_cnt;
    logic [WIDTH_W-1:0] pix_nxt;
    logic [WIDTH_W-1:0] pix_target;
    logic [1:0]         hist_dir;
    logic               hist_vld;
    logic               tmo_expired;

    assign pix_nxt    = pix_cnt + 1'b1;
    assign pix_target = {pathWidth[3:0], 1'b1};
    assign busy       = (state != S_IDLE);

    step_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (10)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .en      (state == S_SCAN),
        .clr     (video_data_valid),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            isDirDefined <= 1'b0;
            direction    <= DIR_DOWN;
            longStep     <= 1'b0;
            pathWidth    <= MIN_W;
            step_valid   <= 1'b0;
            step_dir     <= DIR_DOWN;
            step_coord   <= '0;
            lost         <= 1'b0;
            pix_cnt      <= '0;
            hist_dir     <= DIR_DOWN;
            hist_vld     <= 1'b0;
        end else begin
            lost <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_WAIT_DIR;
                end
                S_WAIT_DIR: begin
                    if (dir_valid) begin
                        direction    <= dir_in;
                        pathWidth    <= clamp_width(width_in);
                        longStep     <= hist_vld && (dir_in == hist_dir);
                        isDirDefined <= 1'b1;
                        pix_cnt      <= '0;
                        state        <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // A pixel takes priority over a coincident expiry; the watchdog clears on it anyway.
                    if (video_data_valid) begin
                        pix_cnt <= pix_nxt;
                        if (pix_nxt == pix_target) state <= S_SETTLE;
                    end else if (tmo_expired) begin
                        lost         <= 1'b1;
                        isDirDefined <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    step_coord <= coord_in;
                    step_dir   <= direction;
                    step_valid <= 1'b1;
                    state      <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (step_ready) begin
                        step_valid   <= 1'b0;
                        isDirDefined <= 1'b0;
                        hist_dir     <= direction;
                        hist_vld     <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: a table of full steps plus hand-written timeout,
// stall and mid-scan reset sequences, with a queue of expected step results.
module tb_step_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic [4:0] width_in = 5'd0;
    logic       video_data_valid = 1'b0;
    logic [4:0] coord_in = 5'd0;
    logic       step_ready = 1'b0;
    logic       isDirDefined;
    logic [1:0] direction;
    logic       longStep;
    logic [4:0] pathWidth;
    logic       step_valid;
    logic [1:0] step_dir;
    logic [4:0] step_coord;
    logic       busy;
    logic       lost;

    step_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .dir_valid        (dir_valid),
        .dir_in           (dir_in),
        .width_in         (width_in),
        .video_data_valid (video_data_valid),
        .coord_in         (coord_in),
        .isDirDefined     (isDirDefined),
        .direction        (direction),
        .longStep         (longStep),
        .pathWidth        (pathWidth),
        .step_valid       (step_valid),
        .step_dir         (step_dir),
        .step_coord       (step_coord),
        .step_ready       (step_ready),
        .busy             (busy),
        .lost             (lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dir;
        logic [4:0] coord;
    } exp_t;

    typedef struct {
        logic [1:0] dir;
        logic [4:0] width;
        logic [4:0] coord;
        int         ready_lat;
        logic       exp_long;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete step; ready_lat cycles of stall with stray start/pixels before accept.
    task automatic do_step(input logic [1:0] d, input logic [4:0] w, input logic [4:0] c,
                           input int ready_lat, input logic exp_long);
        logic [4:0] exp_pw;
        int         npix;
        exp_t       e;
        exp_pw = (w < 5'd1) ? 5'd1 : w;
        npix   = 2 * int'(exp_pw % 5'd16) + 1;
        chk("idle_busy", busy, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("wait_busy", busy, 1);
        dir_valid = 1'b1; dir_in = d; width_in = w;
        tick;
        dir_valid = 1'b0;
        width_in = 5'd17;
        chk("isDirDefined", isDirDefined, 1);
        chk("direction", direction, d);
        chk("longStep", longStep, exp_long);
        chk("pathWidth", pathWidth, exp_pw);
        e.dir = d; e.coord = c;
        sb.push_back(e);
        coord_in = c;
        for (int i = 0; i < npix; i++) begin
            video_data_valid = 1'b1;
            tick;
            if (step_valid !== 1'b0) chk("early_valid", step_valid, 0);
        end
        n_cmp++;
        video_data_valid = 1'b0;
        tick;
        chk("latency_valid", step_valid, 1);
        coord_in = ~c;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("step_dir", step_dir, e.dir);
            chk("step_coord", step_coord, e.coord);
            for (int k = 0; k < ready_lat; k++) begin
                start = 1'b1;
                video_data_valid = 1'b1;
                coord_in = 5'($urandom_range(0, 31));
                tick;
                if (step_valid !== 1'b1 || step_coord !== e.coord || step_dir !== e.dir) begin
                    chk("stall_stable", {step_valid, step_dir, step_coord}, {1'b1, e.dir, e.coord});
                end
            end
            n_cmp++;
        end
        start = 1'b0;
        video_data_valid = 1'b0;
        step_ready = 1'b1;
        tick;
        step_ready = 1'b0;
        chk("accept_valid", step_valid, 0);
        chk("accept_isDir", isDirDefined, 0);
        chk("accept_busy", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_isDir"}, isDirDefined, 0);
        chk({tag, "_long"}, longStep, 0);
        chk({tag, "_dir"}, direction, 0);
        chk({tag, "_pw"}, pathWidth, 1);
        chk({tag, "_valid"}, step_valid, 0);
        chk({tag, "_sdir"}, step_dir, 0);
        chk({tag, "_scoord"}, step_coord, 0);
        chk({tag, "_lost"}, lost, 0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{dir: 2'b10, width: 5'd3,  coord: 5'h15, ready_lat: 0,  exp_long: 1'b0};
        vecs[1] = '{dir: 2'b11, width: 5'd1,  coord: 5'h03, ready_lat: 0,  exp_long: 1'b0};
        vecs[2] = '{dir: 2'b11, width: 5'd2,  coord: 5'h09, ready_lat: 20, exp_long: 1'b1};
        vecs[3] = '{dir: 2'b00, width: 5'd0,  coord: 5'h1F, ready_lat: 0,  exp_long: 1'b0};
        vecs[4] = '{dir: 2'b01, width: 5'd15, coord: 5'h0A, ready_lat: 1,  exp_long: 1'b0};
        vecs[5] = '{dir: 2'b01, width: 5'd20, coord: 5'h07, ready_lat: 0,  exp_long: 1'b1};

        #12;
        chk_reset_vals("rst");
        reset = 1'b1;
        tick;

        for (int v = 0; v < 6; v++) begin
            do_step(vecs[v].dir, vecs[v].width, vecs[v].coord, vecs[v].ready_lat, vecs[v].exp_long);
        end

        // Timeout after two pixels; history (last dir 01) must survive the abort.
        start = 1'b1; tick; start = 1'b0;
        dir_valid = 1'b1; dir_in = 2'b10; width_in = 5'd2; tick; dir_valid = 1'b0;
        video_data_valid = 1'b1; tick; tick; video_data_valid = 1'b0;
        cyc = 0;
        while (lost !== 1'b1 && cyc < 1100) begin
            tick;
            cyc++;
        end
        chk("timeout_cycles", cyc, 1023);
        chk("timeout_isDir", isDirDefined, 0);
        chk("timeout_busy", busy, 0);
        tick;
        chk("lost_pulse_end", lost, 0);
        do_step(2'b01, 5'd1, 5'h11, 0, 1'b1);

        // Reset after 4 of 9 pixels.
        start = 1'b1; tick; start = 1'b0;
        dir_valid = 1'b1; dir_in = 2'b11; width_in = 5'd4; tick; dir_valid = 1'b0;
        video_data_valid = 1'b1;
        repeat (4) tick;
        video_data_valid = 1'b0;
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        #3 reset = 1'b1;
        tick;
        chk("post_reset_lost", lost, 0);
        do_step(2'b11, 5'd4, 5'h0C, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
